div_ctrl: RTL and testbench

//  Multi-cycle radix-2 restoring divider with sequencing FSM for DIV/DIVU; sits beside the EX stage.

---
 rtl/div_ctrl.sv | 137 +++++++++++++
 tb/tb_div_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with sequencing FSM; quotient->LO, remainder->HI.
// Optional feature macro: DIV_EARLY_OUT_EN (finish in one cycle when |dividend| < |divisor|).
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] opv1,
  input  logic [WIDTH-1:0] opv2,
  input  logic             annul,
  output logic             stall_o,
  output logic             done,
  output logic             we_hilo,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_sh, rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             accept, load_res;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    mag1 = (signed_op && opv1[WIDTH-1]) ? (~opv1 + 1'b1) : opv1;
    mag2 = (signed_op && opv2[WIDTH-1]) ? (~opv2 + 1'b1) : opv2;

    // One restoring step: shift quotient MSB into remainder, subtract if it fits.
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    quo_n  = {quo[WIDTH-2:0], 1'b0};
    rem_n  = rem_sh;
    if (rem[WIDTH] || (rem_sh >= {1'b0, dvs})) begin
      rem_n    = rem_sh - {1'b0, dvs};
      quo_n[0] = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    stall_o  = 1'b0;
    accept   = 1'b0;
    load_res = 1'b0;
    res_hi   = '0;
    res_lo   = '0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          if (opv2 == '0) begin
            state_n = DIVZERO;
`ifdef DIV_EARLY_OUT_EN
          end else if (mag1 < mag2) begin
            state_n  = DONE;
            load_res = 1'b1;
            res_hi   = opv1;
            res_lo   = '0;
`endif
          end else begin
            state_n = RUN;
          end
        end
      end
      DIVZERO: begin
        stall_o = 1'b1;
        if (annul) begin
          state_n = IDLE;
        end else begin
          state_n  = DONE;
          load_res = 1'b1;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (annul) begin
          state_n = IDLE;
        end else if (cnt == CW'(WIDTH - 1)) begin
          state_n  = DONE;
          load_res = 1'b1;
          res_lo   = neg_q ? (~quo_n + 1'b1) : quo_n;
          res_hi   = neg_r ? (~rem_n[WIDTH-1:0] + 1'b1) : rem_n[WIDTH-1:0];
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign done    = (state == DONE);
  assign we_hilo = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt   <= '0;
        rem   <= '0;
        quo   <= mag1;
        dvs   <= mag2;
        neg_q <= signed_op && (opv1[WIDTH-1] ^ opv2[WIDTH-1]);
        neg_r <= signed_op && opv1[WIDTH-1];
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        rem <= rem_n;
        quo <= quo_n;
      end
      if (load_res) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, results, annul, reset and back-to-back behaviour.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, annul;
  logic [31:0] opv1, opv2;
  logic        stall_o, done, we_hilo;
  logic [31:0] hi_o, lo_o;

  int n_chk  = 0;
  int n_fail = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .opv1(opv1), .opv2(opv2), .annul(annul),
    .stall_o(stall_o), .done(done), .we_hilo(we_hilo),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge in an IDLE cycle; returns at the negedge of the cycle after done.
  task automatic run_op(input string tag, input logic sop, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic hold_start);
    int cyc;
    int n_done;
    logic stall_ok;
    start = 1'b1; signed_op = sop; opv1 = a; opv2 = b;
    #1 chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    @(negedge clk);
    cyc = 1; n_done = 0; stall_ok = 1'b1;
    start = hold_start; opv1 = ~a; opv2 = 32'h0; signed_op = ~sop;
    #1;
    while (done !== 1'b1 && cyc < 60) begin
      if (stall_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_we"}, 32'(we_hilo), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    if (done === 1'b1) n_done++;
    start = 1'b0;
    @(negedge clk);
    #1 chk({tag, "_pulse"}, 32'(done), 32'd0);
    if (hold_start) chk({tag, "_single_done"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; annul = 1'b0; opv1 = '0; opv2 = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we_hilo), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 32'd0, 32'd0, 1'b0);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);

    // Annul mid-run: no done, IDLE afterwards, previous result retained.
    start = 1'b1; signed_op = 1'b0; opv1 = 32'd1000; opv2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    begin
      int seen_done = 0;
      for (int c = 1; c < 10; c++) begin
        #1 if (done === 1'b1) seen_done++;
        @(negedge clk);
      end
      annul = 1'b1;
      #1 if (done === 1'b1) seen_done++;
      @(negedge clk);
      annul = 1'b0;
      #1;
      chk("annul_no_done", 32'(seen_done + int'(done)), 32'd0);
      chk("annul_idle_stall", 32'(stall_o), 32'd0);
      chk("annul_hi_kept", hi_o, 32'd0);
      chk("annul_lo_kept", lo_o, 32'h8000_0000);
    end
    run_op("after_annul", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

    run_op("hold_start", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b1);
    run_op("back_to_back", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1, 1'b0);

    // Synchronous reset at cycle 5 of a run.
    start = 1'b1; signed_op = 1'b0; opv1 = 32'd50; opv2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef DIV_EARLY_OUT_EN
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1, 32'd0, 32'd3, 1'b0);
`else
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 33, 32'd0, 32'd3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
